ram_banked_ctl: RTL and testbench
=================================

// Module: ram_banked_ctl
// PURPOSE
//   Parametrised banked RAM, generalising the fixed 4x8 two-bank RAM. Upper
//   address bits select the bank and lower bits select the line.
//   - Valid/ready request port, registered 1-cycle read response.
//   - Sweep-clear FSM that zeroes every word, run at reset and on demand.
//   - Serves as the data store behind the register-file and stack blocks.
// PARAMETERS
//   DATA_W  8  word width in bits
//   ADDR_W  4  address width; DEPTH = 2**ADDR_W words
//   BANK_W  1  bank-select width; BANKS = 2**BANK_W; LINES = 2**(ADDR_W-BANK_W)
// PORTS
//   clk          in   1       clock, all state updates on rising edge
//   clr          in   1       synchronous active-low reset
//   req_valid    in   1       request present
//   req_ready    out  1       request accepted when req_valid & req_ready
//   req_rw       in   1       1 = write, 0 = read
//   req_addr     in   ADDR_W  [ADDR_W-1 -: BANK_W] = bank, low bits = line
//   req_data     in   DATA_W  write data
//   rsp_valid    out  1       read data valid, one-cycle pulse per read
//   rsp_data     out  DATA_W  read data
//   rsp_bank     out  BANK_W  bank that produced rsp_data
//   clear_start  in   1       request a full-memory clear
//   busy         out  1       clear sweep in progress
// BEHAVIOUR
//   Reset
//   - clr sampled low at an edge gives: rsp_valid=0, rsp_data=0, rsp_bank=0.
//   - Sweep counter goes to 0 and state goes to S_CLEAR.
//   - busy=1 and req_ready=0 from the next cycle onward.
//   - clr low mid-sweep restarts the sweep at line 0.
//   - clr has priority over every other input.
//   States
//   - S_CLEAR: each cycle writes 0 to line cnt of ALL banks, then cnt++.
//     - When cnt==LINES-1, go to S_RUN next cycle.
//     - The sweep lasts exactly LINES cycles; clear_start is ignored.
//   - S_RUN: serves requests. clear_start=1 moves to S_CLEAR with cnt=0.
//   Outputs
//   - busy = (state==S_CLEAR).
//   - req_ready = (state==S_RUN) & ~clear_start. Combinational, so a request
//     in the same cycle as clear_start is NOT accepted.
//   Write accept
//   - mem[bank][line] <= req_data at that edge; no response.
//   - Only the selected bank is written; other banks hold.
//   Read accept at edge t
//   - At t+1: rsp_valid=1, rsp_data=mem[bank][line], rsp_bank=bank.
//   - A read accepted the cycle right after a write to the same address
//     returns the new data.
//   - A read accepted in the cycle before clear_start still responds, with
//     pre-clear data.
//   - rsp_valid=0 in every cycle without a preceding accepted read.
//   - rsp_data and rsp_bank hold their last value while rsp_valid=0.
//   Other rules
//   - One request per cycle, so there is no read/write address collision.
//   - Back-to-back reads are accepted every cycle with full throughput.
//   - Addresses are full power-of-two, so there is no out-of-range case.
//   - Elaboration error if BANK_W >= ADDR_W or DATA_W < 1.
// TESTING
//   Use defaults: 16 words, 2 banks, 8 lines.
//   1. Reset: clr=0 for 1 cycle, then 1.
//      -> busy=1, req_ready=0 for exactly 8 cycles, then busy=0 and
//         req_ready=1. Reading all 16 addrs gives 0x00 each, rsp_valid
//         one cycle after each accept.
//   2. Bank isolation: write 0xA5@0x3 and 0x5A@0xB, then read 0x3, 0xB,
//      0x2 back-to-back.
//      -> rsp 0xA5/bank0, 0x5A/bank1, 0x00/bank0 on 3 consecutive cycles.
//   3. Write then read: write 0x3C@0x7 at cycle t, read 0x7 at t+1.
//      -> rsp_data=0x3C at t+2. No rsp_valid pulse at t+1.
//   4. Clear collision: fill all addrs with 0xFF. Assert clear_start together
//      with a write 0x11@0x4.
//      -> write not accepted (req_ready=0), busy for 8 cycles. Afterwards all
//         reads return 0x00, including 0x4.
//   5. Reset mid-sweep: clr=0 on sweep cycle 4.
//      -> sweep restarts and busy stays high 8 more cycles. rsp_valid=0 and
//         rsp_data=0 during reset.
//   6. Hold: a read of 0x9 returning 0x77, then 5 idle cycles.
//      -> rsp_valid=0, rsp_data stays 0x77, rsp_bank stays 1.

Source files
------------

// File: rtl/ram_banked_ctl_if.sv
// Request/response bundle for ram_banked_ctl: valid/ready request, registered read response,
// and the clear control/status pair.
interface ram_banked_ctl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BANK_W = 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [BANK_W-1:0] rsp_bank;
    logic              clear_start;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_data, clear_start,
        input  req_ready, rsp_valid, rsp_data, rsp_bank, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, clear_start,
        output req_ready, rsp_valid, rsp_data, rsp_bank, busy
    );
endinterface

// File: rtl/ram_banked_ctl.sv
// Banked RAM with a valid/ready request port, 1-cycle registered read response and a
// sweep-clear engine that zeroes one line of every bank per cycle.
module ram_banked_ctl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BANK_W = 1
) (
    input logic             clk,
    input logic             clr,
    ram_banked_ctl_if.slave bus
);
    localparam int unsigned LINE_W = ADDR_W - BANK_W;
    localparam int unsigned BANKS  = 2 ** BANK_W;
    localparam int unsigned LINES  = 2 ** LINE_W;

    if (BANK_W >= ADDR_W || DATA_W < 1) begin : g_param_check
        $error("ram_banked_ctl: need BANK_W < ADDR_W and DATA_W >= 1");
    end

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] cnt_q, cnt_d;
    logic              ready;
    logic              wr_acc, rd_acc;
    logic [BANK_W-1:0] bank;
    logic [LINE_W-1:0] line;

    logic [DATA_W-1:0] mem_q [BANKS][LINES];
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [BANK_W-1:0] rsp_bank_q;

    assign bank   = bus.req_addr[ADDR_W-1 -: BANK_W];
    assign line   = bus.req_addr[LINE_W-1:0];
    assign wr_acc = bus.req_valid & ready & bus.req_rw;
    assign rd_acc = bus.req_valid & ready & ~bus.req_rw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A request coinciding with clear_start is refused, never half-served.
                ready = ~bus.clear_start;
                if (bus.clear_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_bank_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rd_acc;
            if (rd_acc) begin
                rsp_data_q <= mem_q[bank][line];
                rsp_bank_q <= bank;
            end
        end
    end

    // Storage has no reset of its own; the sweep that follows every reset zeroes it.
    always_ff @(posedge clk) begin
        if (clr) begin
            if (state_q == StClear) begin
                for (int b = 0; b < int'(BANKS); b++) begin
                    mem_q[b][cnt_q] <= '0;
                end
            end else if (wr_acc) begin
                mem_q[bank][line] <= bus.req_data;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.busy      = (state_q == StClear);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_bank  = rsp_bank_q;
endmodule

// File: tb/tb_ram_banked_ctl.sv
// Bench for ram_banked_ctl at default sizing (16 words, 2 banks, 8 lines): memory model plus
// per-cycle compare, and directed sequences with literal expectations.
module tb_ram_banked_ctl;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    ram_banked_ctl_if bus ();

    ram_banked_ctl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: flat 16-word memory, remaining-sweep count, expected response registers.
    logic [7:0] m_mem [16];
    int         m_clear_left = 0;
    bit         m_known      = 1'b0;
    logic       m_valid      = 1'b0;
    logic [7:0] m_data       = '0;
    logic       m_bank       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_zero();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    always @(posedge clk) begin
        if (!clr) begin
            m_clear_left = 8;
            m_zero();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_bank  = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            m_valid = 1'b0;
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else if (bus.clear_start) begin
                m_clear_left = 8;
                m_zero();
            end else if (bus.req_valid) begin
                if (bus.req_rw) begin
                    m_mem[bus.req_addr] = bus.req_data;
                end else begin
                    m_valid = 1'b1;
                    m_data  = m_mem[bus.req_addr];
                    m_bank  = bus.req_addr[3];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", bus.busy, m_clear_left > 0);
            chk("req_ready", bus.req_ready, (m_clear_left == 0) && !bus.clear_start);
            chk("rsp_valid", bus.rsp_valid, m_valid);
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rsp_bank", bus.rsp_bank, m_bank);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = a;
        step();
        bus.req_valid = 1'b0;
        chk({name, "_valid"}, bus.rsp_valid, 1'b1);
        chk({name, "_data"}, bus.rsp_data, d);
        chk({name, "_bank"}, bus.rsp_bank, a[3]);
    endtask

    initial begin
        int n;
        clr             = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_rw      = 1'b0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.clear_start = 1'b0;

        // Reset and initial sweep
        step();
        clr = 1'b1;
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_data", bus.rsp_data, 8'h00);
        count_busy(n);
        chk("reset_busy_cycles", n, 8);
        chk("reset_ready_after", bus.req_ready, 1'b1);
        for (int a = 0; a < 16; a++) rd_chk("init_read", 4'(a), 8'h00);

        // Bank isolation, back-to-back reads
        wr(4'h3, 8'hA5);
        wr(4'hB, 8'h5A);
        rd_chk("iso_3", 4'h3, 8'hA5);
        rd_chk("iso_b", 4'hB, 8'h5A);
        rd_chk("iso_2", 4'h2, 8'h00);
        step();
        chk("iso_idle_valid", bus.rsp_valid, 1'b0);

        // Read right after write to the same address
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 4'h7;
        bus.req_data  = 8'h3C;
        step();
        bus.req_rw = 1'b0;
        chk("wr_no_rsp", bus.rsp_valid, 1'b0);
        step();
        bus.req_valid = 1'b0;
        chk("raw_valid", bus.rsp_valid, 1'b1);
        chk("raw_data", bus.rsp_data, 8'h3C);

        // Clear colliding with a write
        for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF);
        rd_chk("fill_4", 4'h4, 8'hFF);
        bus.clear_start = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_rw      = 1'b1;
        bus.req_addr    = 4'h4;
        bus.req_data    = 8'h11;
        #1;
        chk("collide_ready", bus.req_ready, 1'b0);
        step();
        bus.clear_start = 1'b0;
        bus.req_valid   = 1'b0;
        count_busy(n);
        chk("clear_busy_cycles", n, 8);
        for (int a = 0; a < 16; a++) rd_chk("post_clear", 4'(a), 8'h00);

        // Hold after a read
        wr(4'h9, 8'h77);
        rd_chk("hold_read", 4'h9, 8'h77);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", bus.rsp_valid, 1'b0);
            chk("hold_data", bus.rsp_data, 8'h77);
            chk("hold_bank", bus.rsp_bank, 1'b1);
        end

        // Reset in the middle of a sweep
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        step();
        step();
        step();
        chk("mid_busy_before", bus.busy, 1'b1);
        clr = 1'b0;
        step();
        clr = 1'b1;
        chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rsp_data", bus.rsp_data, 8'h00);
        count_busy(n);
        chk("mid_busy_cycles", n, 8);
        rd_chk("mid_after_9", 4'h9, 8'h00);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
